// File: rtl/alu_writeback_buffer.sv
// In-order write-back buffer between the ALU result path and the register-file write port.
// Holds up to DEPTH results, tracks the architectural zero flag and offers operand forwarding.
module alu_writeback_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [DATA_W-1:0]          res_data,
  input  logic                       res_zero,
  input  logic [REG_AW-1:0]          res_dst,
  input  logic                       res_wen,
  input  logic                       flush,
  output logic                       rf_we,
  output logic [REG_AW-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  input  logic                       rf_busy,
  output logic                       zero_flag,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [REG_AW-1:0]          hazard_dst,
  output logic                       hazard_hit,
  output logic [DATA_W-1:0]          fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              zero;
    logic [REG_AW-1:0] dst;
    logic              wen;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            zero_flag_q, zero_flag_d;

  entry_t          head;
  entry_t          new_entry;
  logic            head_vld;
  logic            enq;
  logic            retire;

  // Handshake and write-port control; res_ready depends on count_q alone.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    head      = mem_q[rd_ptr_q];
    head_vld  = (count_q != '0);
    res_ready = (count_q != CW'(DEPTH));
    enq       = res_valid && res_ready && !flush;
    retire    = head_vld && !flush && (!head.wen || !rf_busy);
    rf_we     = head_vld && head.wen && !flush;
    rf_waddr  = head_vld ? head.dst  : '0;
    rf_wdata  = head_vld ? head.data : '0;

    new_entry.data = res_data;
    new_entry.zero = res_zero;
    new_entry.dst  = res_dst;
    new_entry.wen  = res_wen;

    rd_ptr_d    = rd_ptr_q + PW'(retire);
    wr_ptr_d    = wr_ptr_q + PW'(enq);
    zero_flag_d = retire ? head.zero : zero_flag_q;
    count_d     = count_q;
    case ({enq, retire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Walk entries oldest to youngest so the last match wins as the forwarded value.
  always_comb begin
    logic [PW-1:0] idx;
    hazard_hit = 1'b0;
    fwd_data   = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && mem_q[idx].wen && (mem_q[idx].dst == hazard_dst)) begin
        hazard_hit = 1'b1;
        fwd_data   = mem_q[idx].data;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  // NOTE: payload storage is not reset; validity comes from count_q and the pointers.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= new_entry;
  end

  assign count     = count_q;
  assign zero_flag = zero_flag_q;

endmodule
